muldiv_unit: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers, parametrised in operand width. It is the datapath successor to the fixed single-cycle MULTU/HILO path. It supports signed and unsigned multiply and divide (MULT/MULTU/DIV/DIVU) and MTHI/MTLO writes. The control decoder drives op/start; the datapath reads hi/lo for MFHI/MFLO and stalls on busy.

---
 rtl/muldiv_pkg.sv | 19 +
 rtl/muldiv_unit.sv | 136 +++++++++++++
 tb/tb_muldiv_unit.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states
// and the iteration counter width helper.
package muldiv_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FIXUP = 2'd2;

  // Counter must hold WIDTH itself, hence WIDTH+1 values.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO. One bit per cycle
// on a shared 2*WIDTH accumulator, magnitudes in, sign correction in FIXUP.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = cnt_width(WIDTH);

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic [WIDTH-1:0]   opb;
  logic [2*WIDTH-1:0] acc;

  // Start-side sign handling
  logic             sop, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    sop   = SIGNED_EN && op[0];
    a_neg = sop && a[WIDTH-1];
    b_neg = sop && b[WIDTH-1];
    a_mag = a_neg ? WIDTH'(-a) : a;
    b_mag = b_neg ? WIDTH'(-b) : b;
  end

  // Shared iteration step: shift-add for multiply, restoring step for divide.
  // Divide keeps remainder in acc[2W-1:W] and shifts quotient bits into acc[W-1:0].
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   step_next;

  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb};
    step_next = {mul_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (div_diff[WIDTH])
        step_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
        step_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end

  // Fixup-side sign correction
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    prod_fix = neg_q ? (2*WIDTH)'(-acc) : acc;
    quo_fix  = neg_q ? WIDTH'(-acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    rem_fix  = neg_r ? WIDTH'(-acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      opb    <= '0;
      acc    <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_RUN;
            cnt    <= CW'(WIDTH);
            is_div <= op[1];
            // A zero divisor keeps the natural all-ones quotient unsigned.
            neg_q  <= (a_neg ^ b_neg) && (|b);
            neg_r  <= a_neg;
            opb    <= b_mag;
            acc    <= {{WIDTH{1'b0}}, a_mag};
          end
        end
        S_RUN: begin
          acc <= step_next;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= S_FIXUP;
        end
        S_FIXUP: begin
          state <= S_IDLE;
          done  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // HI/LO: MT writes only while idle; FIXUP is the only other writer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (state == S_FIXUP) begin
      if (is_div) begin
        hi <= rem_fix;
        lo <= quo_fix;
      end else begin
        hi <= prod_fix[2*WIDTH-1:WIDTH];
        lo <= prod_fix[WIDTH-1:0];
      end
    end else if (state == S_IDLE) begin
      if (hi_we) hi <= wd;
      if (lo_we) lo <= wd;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: signed and unsigned-only instances side by
// side, directed vector table, random ops against an arithmetic model, corner sequences.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0, b = '0, wd = '0;
  logic         hi_we = 1'b0, lo_we = 1'b0;

  logic         busy_s, done_s, busy_u, done_u;
  logic [W-1:0] hi_s, lo_s, hi_u, lo_u;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W), .SIGNED_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wd(wd),
    .busy(busy_s), .done(done_s), .hi(hi_s), .lo(lo_s)
  );

  muldiv_unit #(.WIDTH(W), .SIGNED_EN(1'b0)) u_dut_u (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wd(wd),
    .busy(busy_u), .done(done_u), .hi(hi_u), .lo(lo_u)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Arithmetic reference: returns {hi, lo}.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                        input logic [31:0] y, input bit sgn);
    bit signed_op;
    longint sx, sy;
    logic [63:0] ux, uy;
    int xi, yi, q, r;
    signed_op = sgn && o[0];
    if (!o[1]) begin
      if (signed_op) begin
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        return 64'(sx * sy);
      end
      ux = {32'd0, x};
      uy = {32'd0, y};
      return ux * uy;
    end
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (signed_op) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      xi = x;
      yi = y;
      q = xi / yi;
      r = xi % yi;
      return {32'(r), 32'(q)};
    end
    return {x % y, x / y};
  endfunction

  // Full operation: checks busy span, no early done, done pulse and result.
  task automatic do_op(input string nm, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [63:0] es, input logic [63:0] eu);
    int bc;
    bit early;
    bc = 0;
    early = 1'b0;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    if (busy_s && busy_u) bc++;
    for (int i = 1; i <= W; i++) begin
      @(posedge clk); #1;
      if (busy_s && busy_u) bc++;
      if (done_s || done_u) early = 1'b1;
    end
    chk({nm, " busy cycles"}, 64'(bc), 64'(W + 1));
    chk({nm, " early done"}, 64'(early), 64'd0);
    @(posedge clk); #1;
    chk({nm, " done/busy"}, {60'd0, done_s, done_u, busy_s, busy_u}, 64'b1100);
    chk({nm, " result signed"}, {hi_s, lo_s}, es);
    chk({nm, " result unsigned"}, {hi_u, lo_u}, eu);
  endtask

  typedef struct {
    string       nm;
    logic [1:0]  o;
    logic [31:0] x, y;
    logic [63:0] es, eu;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [1:0]  ro;
    logic [31:0] rx, ry;
    logic [63:0] got;
    int          dcnt;

    vecs[0] = '{"multu max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFE_0000_0001};
    vecs[1] = '{"mult -3*5", OP_MULT, 32'hFFFF_FFFD, 32'd5,
                64'hFFFF_FFFF_FFFF_FFF1, 64'h0000_0004_FFFF_FFF1};
    vecs[2] = '{"div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2,
                64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0001_7FFF_FFFC};
    vecs[3] = '{"divu 7/0", OP_DIVU, 32'd7, 32'd0,
                64'h0000_0007_FFFF_FFFF, 64'h0000_0007_FFFF_FFFF};
    vecs[4] = '{"div min/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
                64'h0000_0000_8000_0000, 64'h8000_0000_0000_0000};
    vecs[5] = '{"div -7/0", OP_DIV, 32'hFFFF_FFF9, 32'd0,
                64'hFFFF_FFF9_FFFF_FFFF, 64'hFFFF_FFF9_FFFF_FFFF};
    vecs[6] = '{"multu 6*7", OP_MULTU, 32'd6, 32'd7,
                64'h0000_0000_0000_002A, 64'h0000_0000_0000_002A};
    vecs[7] = '{"div 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE,
                64'h0000_0001_FFFF_FFFD, 64'h0000_0007_0000_0000};

    // Reset state
    #12;
    chk("reset state", {hi_s, lo_s, 30'd0, busy_s, done_s},
        {32'd0, 32'd0, 30'd0, 1'b0, 1'b0});
    @(negedge clk); rst = 1'b0;

    // Directed table (consecutive entries exercise back-to-back start in done cycle)
    for (int i = 0; i < 8; i++)
      do_op(vecs[i].nm, vecs[i].o, vecs[i].x, vecs[i].y, vecs[i].es, vecs[i].eu);
    @(posedge clk); #1;
    chk("done one cycle", {62'd0, done_s, done_u}, 64'd0);

    // Random ops against the model
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      case ($urandom_range(0, 5))
        0: ry = 32'd0;
        1: ry = 32'hFFFF_FFFF;
        2: ry = 32'($urandom_range(1, 16));
        default: ry = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) rx = 32'h8000_0000;
      do_op("random", ro, rx, ry, model(ro, rx, ry, 1'b1), model(ro, rx, ry, 1'b0));
    end

    // start re-pulsed mid-operation is ignored
    @(negedge clk);
    start = 1'b1; op = OP_MULT; a = 32'hFFFF_FFFD; b = 32'd5;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd3;
    @(posedge clk); #1; start = 1'b0;
    dcnt = 0;
    got = '0;
    for (int i = 0; i < W + 6; i++) begin
      @(posedge clk); #1;
      if (done_s) begin
        dcnt++;
        got = {hi_s, lo_s};
      end
    end
    chk("repulse done count", 64'(dcnt), 64'd1);
    chk("repulse result", got, 64'hFFFF_FFFF_FFFF_FFF1);

    // MT writes: idle takes effect, busy is ignored
    @(negedge clk); lo_we = 1'b1; wd = 32'h0000_1234;
    @(posedge clk); #1; lo_we = 1'b0;
    chk("mtlo idle", 64'(lo_s), 64'h1234);
    @(negedge clk); hi_we = 1'b1; wd = 32'h0000_5678;
    @(posedge clk); #1; hi_we = 1'b0;
    chk("mthi idle", 64'(hi_s), 64'h5678);
    @(negedge clk); start = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd3;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); lo_we = 1'b1; hi_we = 1'b1; wd = 32'hDEAD_BEEF;
    @(posedge clk); #1; lo_we = 1'b0; hi_we = 1'b0;
    chk("mt while busy", {hi_s, lo_s}, 64'h0000_5678_0000_1234);
    for (int i = 0; i < W + 4 && !done_s; i++) begin
      @(posedge clk); #1;
    end
    chk("op after busy mt", {31'd0, done_s, hi_s, lo_s}, {31'd0, 1'b1, 64'd9});

    // MT write coincident with start: visible until the result lands
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; a = 32'd6; b = 32'd7;
    lo_we = 1'b1; hi_we = 1'b1; wd = 32'h0000_ABCD;
    @(posedge clk); #1;
    start = 1'b0; lo_we = 1'b0; hi_we = 1'b0;
    chk("mt+start early", {hi_s, lo_s}, 64'h0000_ABCD_0000_ABCD);
    repeat (W) @(posedge clk);
    #1;
    chk("mt+start pre-fixup", {hi_s, lo_s}, 64'h0000_ABCD_0000_ABCD);
    @(posedge clk); #1;
    chk("mt+start result", {31'd0, done_s, hi_s, lo_s}, {31'd0, 1'b1, 64'd42});

    // Asynchronous reset mid-RUN aborts with no done pulse
    @(negedge clk); lo_we = 1'b1; hi_we = 1'b1; wd = 32'h0000_0055;
    @(posedge clk); #1; lo_we = 1'b0; hi_we = 1'b0;
    @(negedge clk); start = 1'b1; op = OP_MULTU; a = 32'd1000; b = 32'd1000;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #1;
    chk("async reset", {hi_s, lo_s, 31'd0, busy_s}, 64'd0 << 0 | {32'd0, 32'd0, 31'd0, 1'b0});
    chk("async reset unsigned inst", {hi_u, lo_u}, 64'd0);
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      if (done_s || done_u || busy_s) dcnt++;
    end
    chk("no done after reset", 64'(dcnt), 64'd0);
    do_op("multu 6*7 after reset", OP_MULTU, 32'd6, 32'd7, 64'd42, 64'd42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
